// File: rtl/fetch_if_id_stage_pkg.sv
// Shared fetch-stage constants: NOP encoding, IF/ID source-field positions and the fetch mode decode.
package fetch_if_id_stage_pkg;

  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_REG_W    = 4;
  localparam int DEF_RA_LSB   = 20;
  localparam int DEF_RB_LSB   = 16;
  localparam int PERF_W       = 16;

  // Source fields of the NOP are zero, so a bubble never looks like a register reader.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_STALL,
    MODE_REDIRECT
  } fetchMode_e;

  function automatic fetchMode_e decodeMode(logic enablePc, logic branchTaken);
    if (branchTaken) return MODE_REDIRECT;
    if (enablePc) return MODE_RUN;
    return MODE_STALL;
  endfunction

endpackage

// File: rtl/fetch_if_id_stage_skid.sv
// One-entry holding register {instr, pc, valid} that parks an in-flight fetch response during a stall.
module fetch_skid #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] loadInstr,
  input  logic [ADDR_W-1:0]  loadPc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               valid
);

  // Clear dominates load so a redirect can never leave a stale entry behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= loadInstr;
      pc    <= loadPc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction fetch with IF/ID register, stall skid and branch redirect.
// Optional FETCH_PERF_EN adds saturating stall/flush cycle counters.
module fetch_if_id_stage
  import fetch_if_id_stage_pkg::*;
#(
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                REG_W    = DEF_REG_W,
  parameter int                RA_LSB   = DEF_RA_LSB,
  parameter int                RB_LSB   = DEF_RB_LSB,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_pc,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
`ifdef FETCH_PERF_EN
  output logic [PERF_W-1:0]  perf_stall_cnt,
  output logic [PERF_W-1:0]  perf_flush_cnt,
`endif
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [REG_W-1:0]   if_id_registerA,
  output logic [REG_W-1:0]   if_id_registerB
);

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  fetchMode_e         mode;
  logic [ADDR_W-1:0]  pcQ;
  logic [ADDR_W-1:0]  respPc;
  logic               respV;
  logic               issue;
  logic [INSTR_W-1:0] skidInstr;
  logic [ADDR_W-1:0]  skidPc;
  logic               skidV;
  logic               skidLoad;
  logic               skidClear;
  logic [INSTR_W-1:0] srcInstr;
  logic [ADDR_W-1:0]  srcPc;
  logic               srcV;

  assign mode      = decodeMode(enable_pc, branch_taken);
  assign issue     = enable_pc & ~branch_taken & rst_n;
  assign imem_en   = issue;
  assign imem_addr = pcQ;

  // A parked response is always older than anything on imem_rdata, so it goes first.
  assign srcInstr  = skidV ? skidInstr : imem_rdata;
  assign srcPc     = skidV ? skidPc : respPc;
  assign srcV      = skidV | respV;

  assign skidLoad  = (mode == MODE_STALL) & respV & ~skidV;
  assign skidClear = (mode != MODE_STALL);

  fetch_skid #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) uSkid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skidLoad),
    .clear     (skidClear),
    .loadInstr (imem_rdata),
    .loadPc    (respPc),
    .instr     (skidInstr),
    .pc        (skidPc),
    .valid     (skidV)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcQ    <= RESET_PC;
      respV  <= 1'b0;
      respPc <= '0;
    end else begin
      respV <= issue;
      if (issue) begin
        pcQ    <= pcQ + ADDR_W'(1);
        respPc <= pcQ;
      end else if (mode == MODE_REDIRECT) begin
        pcQ <= branch_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_pc    <= '0;
    end else begin
      case (mode)
        MODE_REDIRECT: begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP;
        end
        MODE_RUN: begin
          if_id_valid <= srcV;
          if_id_instr <= srcV ? srcInstr : NOP;
          if_id_pc    <= srcPc;
        end
        default: begin
        end
      endcase
    end
  end

  assign if_id_registerA = if_id_valid ? if_id_instr[RA_LSB +: REG_W] : '0;
  assign if_id_registerB = if_id_valid ? if_id_instr[RB_LSB +: REG_W] : '0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!enable_pc && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (branch_taken && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule
